embedded_system_copy_master: RTL and testbench
==============================================

# embedded_system_copy_master

Avalon-MM master that copies a block of 32-bit words from one word-address range to another in the on-chip RAM (port s1/s2 of the single-port 1024-word memory). Software or a controller pulses `start` with source, destination and length. The block then performs sequential read-then-write transfers and pulses `done` when finished. It is the initiator end of the memory's slave interface.

## Interface
- `ADDR_W`, 10, word-address width; 1024-word memory.
- `DATA_W`, 32, data width; byteenable width is DATA_W/8.
- `READ_LATENCY`, 1, cycles from read acceptance to valid `avm_readdata`. Value 1 matches unregistered altsyncram output. Legal range 1..4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source word address; latched on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination word address; latched on accepted `start`.
- `length`  in  ADDR_W+1  words to copy, 0..1024; latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle (inclusive).
- `done`  out  1  one-cycle completion pulse.
- `avm_address`  out  ADDR_W  word address.
- `avm_chipselect`  out  1  high during every read or write request.
- `avm_read`  out  1  read request.
- `avm_write`  out  1  write request.
- `avm_byteenable`  out  DATA_W/8  all ones during requests, else 0.
- `avm_writedata`  out  DATA_W  captured read word.
- `avm_readdata`  in  DATA_W  read return.
- `avm_waitrequest`  in  1  slave stall; tie 0 for direct on-chip RAM connection.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE → RD_REQ on `start` when `length` ≠ 0. Latch `src`, `dst` and `remaining`=`length`.
- IDLE → DONE on `start` when `length` = 0. No bus traffic is generated.
- RD_REQ:
  - Assert `avm_chipselect` and `avm_read` with `avm_address`=`src`.
  - Hold all request signals stable while `avm_waitrequest`=1.
  - On acceptance (`waitrequest`=0) → RD_WAIT; latency counter loads READ_LATENCY.
- RD_WAIT:
  - Count down the latency counter.
  - When the counter reaches 0, capture `avm_readdata` into the data register → WR_REQ.
- WR_REQ:
  - Assert `avm_chipselect` and `avm_write` with `avm_address`=`dst` and `avm_writedata`=captured word.
  - Hold stable under waitrequest.
  - On acceptance: `src`++, `dst`++, `remaining`--. Go to RD_REQ if new `remaining` ≠ 0, else DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Address increments wrap modulo 2^ADDR_W (1023 → 0). There is no error on wrap.
- Overlapping ranges are copied strictly in ascending order with no hazard protection. Software must avoid dst > src overlap.
- `start` in any state other than IDLE is ignored; latched values are unaffected.
- `avm_read` and `avm_write` are never high in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `avm_chipselect`=0, `avm_read`=0, `avm_write`=0, `avm_byteenable`=0, `avm_address`=0, `avm_writedata`=0. State is IDLE.
- Reset asserted mid-transfer: all outputs return to reset values asynchronously. The transfer is abandoned, no `done` is issued, and the destination may be partially written.
- Zero wait states, per word: 1 (RD_REQ) + READ_LATENCY (RD_WAIT) + 1 (WR_REQ) cycles. This is 3 cycles with default parameters.
- `start` at cycle 0 → first read request at cycle 1.
- For N words with no stalls, `done` is at cycle 1 + N·(2+READ_LATENCY).
- For `length`=0, `done` is at cycle 1.
- Each waitrequest cycle adds exactly one cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `embedded_system_copy_master_pkg`:
  - State enum.
  - `BYTE_EN_ALL` constant.
  - Default widths.
- Single flat module with no sub-module. The latency counter is a small in-module down-counter sized by $clog2(READ_LATENCY+1).

## Test plan
- Basic copy: preload RAM[0..3]=A0,A1,A2,A3; start src=0, dst=100, len=4.
  - Required: RAM[100..103]=A0..A3.
  - `done` at cycle 13, `busy` high cycles 1–13.
  - Exactly 4 reads and 4 writes.
- Zero length: start len=0.
  - Required: `done` at cycle 1.
  - No `avm_chipselect` assertion.
- Wrap: start src=1022, dst=10, len=4.
  - Reads at 1022, 1023, 0, 1.
  - RAM[10..13] gets those words.
- Waitrequest: random 0–3 stall cycles on each request.
  - Required: request signals stable during each stall.
  - Data correct.
  - Total cycles = nominal + stall count.
- Start while busy: second `start` pulse at cycle 5 with different parameters.
  - Required: ignored.
  - Only the first copy occurs; one `done`.
- Reset mid-op: `reset_n` low at cycle 7 of an 8-word copy.
  - Required: all outputs 0 immediately; no `done`.
  - A new `start` after release copies correctly.

Source files
------------

// File: rtl/embedded_system_copy_master_pkg.sv
// Shared types and defaults for the word-copy Avalon-MM master.
package embedded_system_copy_master_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int READ_LAT_DEF = 1;

  // Wide enough for any data width up to 1024 bits; the master slices what it needs.
  localparam logic [127:0] BYTE_EN_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

endpackage

// File: rtl/embedded_system_copy_master.sv
// Sequential read-then-write block copier on an Avalon-MM master port.
// Every output is a flop loaded from next-state values, so nothing is combinational from inputs.
module embedded_system_copy_master
  import embedded_system_copy_master_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = READ_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ON = BYTE_EN_ALL[BE_W-1:0];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, done_q, cs_q, rd_q, wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic                rd_n, wr_n;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          state_d = (length == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          cnt_d   = CNT_W'(READ_LATENCY);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Last wait cycle: the slave's read word is on the bus now.
        if (cnt_d == '0) begin
          data_d  = avm_readdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_d == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign rd_n = (state_d == ST_RD_REQ);
  assign wr_n = (state_d == ST_WR_REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      cs_q    <= rd_n | wr_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      addr_q  <= rd_n ? src_d : (wr_n ? dst_d : '0);
      be_q    <= (rd_n | wr_n) ? BE_ON : '0;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = data_q;

endmodule

// File: tb/tb_embedded_system_copy_master.sv
// Bench for the copy master: RAM slave with optional random stalls, transaction-level model, per-cycle compare.
module tb_embedded_system_copy_master;
  localparam int AW = 10, DW = 32, LAT = 1, DEPTH = 1024;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [AW:0]   length = '0;
  logic busy, done, avm_chipselect, avm_read, avm_write;
  logic [AW-1:0] avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;
  logic avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  embedded_system_copy_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // RAM contents seen by the bus (mem) and the model's expected image (gold).
  logic [31:0] mem[DEPTH], gold[DEPTH], tmp[DEPTH], exp_data[DEPTH];
  bit exp_active = 0, stall_en = 0, in_req = 0, rd_acc_pend = 0;
  int cyc = 0, st_cyc = 0, exp_len = 0, exp_src = 0, exp_dst = 0;
  int rd_idx = 0, wr_idx = 0, stalls = 0, n_done = 0, done_rel = -1;
  int rd_acc_cyc = 0, wr_acc_cyc = 0, cs_cnt = 0, stall_left = 0;
  logic [AW-1:0] rd_addr = '0, s_addr;
  logic s_rd, s_wr;
  logic [31:0] s_wd;

  // Read word is valid only in the cycle after acceptance; garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    avm_readdata <= rd_acc_pend ? mem[rd_addr] : (32'hBAD0_0000 | 32'(cyc));
  end

  always @(negedge clk) begin
    int rel, dl;
    bit req;
    if (!reset_n) begin
      avm_waitrequest = 1'b0; in_req = 0; rd_acc_pend = 0;
    end else begin
      rel = cyc - st_cyc;
      dl  = 1 + exp_len * (2 + LAT) + stalls;
      if (avm_chipselect) cs_cnt++;
      chk("bus_form", {avm_read & avm_write, avm_chipselect, avm_byteenable},
          {1'b0, avm_read | avm_write, (avm_read | avm_write) ? 4'hF : 4'h0});
      if (exp_active) begin
        chk("busy", busy, (rel >= 1) && (rel <= dl));
        chk("done", done, rel == dl);
        if (rel == dl) begin exp_active = 0; n_done++; done_rel = rel; end
      end else begin
        chk("idle", {busy, done, avm_chipselect}, 3'b000);
      end
      rd_acc_pend = 0;
      req = avm_read | avm_write;
      if (!req) begin
        avm_waitrequest = 1'b0; in_req = 0;
      end else begin
        if (in_req) begin
          chk("stall_stable", {avm_address, avm_read, avm_write, avm_writedata},
              {s_addr, s_rd, s_wr, s_wd});
        end else begin
          in_req = 1;
          stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
          s_addr = avm_address; s_rd = avm_read; s_wr = avm_write; s_wd = avm_writedata;
          if (avm_write) chk("wr_latency", cyc - rd_acc_cyc, LAT + 1);
          else if (rd_idx == 0) chk("first_rd", rel, 1);
          else chk("rd_gap", cyc - wr_acc_cyc, 1);
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1; stall_left--; stalls++;
        end else begin
          avm_waitrequest = 1'b0; in_req = 0;
          if (avm_read) begin
            chk("rd_addr", {exp_active, rd_idx < exp_len, avm_address},
                {2'b11, AW'(exp_src + rd_idx)});
            rd_addr = avm_address; rd_acc_pend = 1; rd_idx++; rd_acc_cyc = cyc;
          end else begin
            chk("wr_addr", {exp_active, wr_idx < exp_len, avm_address},
                {2'b11, AW'(exp_dst + wr_idx)});
            if (wr_idx < exp_len) begin
              chk("wr_data", avm_writedata, exp_data[wr_idx]);
              gold[AW'(exp_dst + wr_idx)] = exp_data[wr_idx];
            end
            mem[avm_address] = avm_writedata;
            wr_idx++; wr_acc_cyc = cyc;
          end
        end
      end
    end
  end

  // Model: ascending word-by-word copy applied to a scratch image gives each write's data.
  task automatic cmd(input int s, input int d, input int n);
    logic [31:0] v;
    @(negedge clk);
    start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); length = (AW+1)'(n);
    for (int i = 0; i < DEPTH; i++) tmp[i] = gold[i];
    for (int i = 0; i < n; i++) begin
      v = tmp[(s + i) % DEPTH]; exp_data[i] = v; tmp[(d + i) % DEPTH] = v;
    end
    exp_src = s; exp_dst = d; exp_len = n; rd_idx = 0; wr_idx = 0; stalls = 0;
    st_cyc = cyc; done_rel = -1; exp_active = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (exp_active && k < 3000) begin @(negedge clk); k++; end
    chk({nm, "_timeout"}, exp_active, 1'b0);
    exp_active = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nd0, cs0, bad;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h5A5A_0000 ^ (i * 32'h0001_0003); gold[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin mem[i] = 32'hCAFE_00A0 + i; gold[i] = mem[i]; end
    mem[1022] = 32'h1111_1022; gold[1022] = mem[1022];
    mem[1023] = 32'h1111_1023; gold[1023] = mem[1023];

    repeat (3) @(negedge clk);
    chk("reset_vals", {busy, done, avm_chipselect, avm_read, avm_write, avm_byteenable,
                       avm_address, avm_writedata}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy
    cmd(0, 100, 4); wait_done("basic");
    chk("basic_done_cyc", done_rel, 13);
    chk("basic_nrd", rd_idx, 4); chk("basic_nwr", wr_idx, 4);
    for (int i = 0; i < 4; i++) chk("basic_ram", mem[100 + i], 32'hCAFE_00A0 + i);

    // Zero length
    cs0 = cs_cnt; nd0 = n_done;
    cmd(5, 6, 0); wait_done("zero");
    chk("zero_done_cyc", done_rel, 1);
    chk("zero_no_cs", cs_cnt - cs0, 0);
    chk("zero_ndone", n_done - nd0, 1);

    // Wrap around the top of memory
    cmd(1022, 10, 4); wait_done("wrap");
    chk("wrap_done_cyc", done_rel, 13);
    chk("wrap_ram0", mem[10], 32'h1111_1022); chk("wrap_ram1", mem[11], 32'h1111_1023);
    chk("wrap_ram2", mem[12], 32'hCAFE_00A0); chk("wrap_ram3", mem[13], 32'hCAFE_00A1);

    // Random stalls on every request
    stall_en = 1;
    cmd(500, 600, 6); wait_done("stall");
    stall_en = 0;
    chk("stall_nwr", wr_idx, 6);

    // Start pulse while busy is ignored
    nd0 = n_done;
    cmd(0, 700, 4);
    while (cyc - st_cyc < 5) @(negedge clk);
    start = 1'b1; src_addr = AW'(900); dst_addr = AW'(950); length = (AW+1)'(2);
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    chk("busy_start_ndone", n_done - nd0, 1);
    chk("busy_start_cyc", done_rel, 13);
    for (int i = 0; i < 4; i++) chk("busy_start_ram", mem[700 + i], 32'hCAFE_00A0 + i);

    // Asynchronous reset in the middle of an 8-word copy
    nd0 = n_done;
    cmd(200, 300, 8);
    while (cyc - st_cyc < 7) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("rst_async", {busy, done, avm_chipselect, avm_read, avm_write, avm_byteenable,
                         avm_address, avm_writedata}, '0);
    chk("rst_partial_wr", wr_idx, 2);
    exp_active = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_done", n_done - nd0, 0);
    cmd(200, 400, 8); wait_done("after_rst");
    chk("after_rst_cyc", done_rel, 25);
    chk("after_rst_ram", mem[407], 32'h5A5A_0000 ^ (207 * 32'h0001_0003));

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
    chk("mem_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
